gate_sweep: RTL and testbench

Parametrised, clocked successor to the fixed three-input gate exerciser. It steps an N-bit input vector through all 2^N combinations, holds each for a programmable number of cycles, and drives NOT and AND2..ANDN reductions of the vector. It also counts sweep results and can compress them into a signature. It sits beside the gate-level blocks as an on-chip sweep source and self-check, replacing hand-written stimulus sequences.

---
 rtl/gate_sweep.sv | 144 ++++++++++++++
 tb/tb_gate_sweep.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep.sv
// gate_sweep: clocked gate exerciser.
// Steps an N-bit vector through all 2^N values, holding each value for HOLD
// cycles. The vector drives NOT and AND2..ANDN reductions. The block counts
// ANDN hits over a sweep and can fold the gate outputs into a signature.
// Optional feature: define GATE_SWEEP_MISR_EN to build the 8-bit MISR on sig.
// Without it, sig is tied to zero.
module gate_sweep #(
    parameter int N    = 3,   // vector width, legal 2..8
    parameter int HOLD = 4    // cycles each vector is held, legal 1..256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    output logic [N-1:0] vec,
    output logic         out_not,
    output logic [N-2:0] out_and,
    output logic         sample,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_cnt,
    output logic [7:0]   sig
);

    localparam int              HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD - 1);
    localparam logic [N-1:0]    VEC_LAST  = '1;
    localparam logic [N:0]      ONES_MAX  = {1'b1, {N{1'b0}}};
    localparam bit              HOLD_ONE  = (HOLD == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [HCW-1:0] hold_cnt;
    logic           start_go;   // a sweep (re)starts at the end of this cycle
    logic           sample_go;  // a sample is committed at the end of this cycle

    // Gate outputs depend on the vec register only, never on an input port.
    assign out_not = ~vec[0];

    for (genvar j = 0; j < N - 1; j++) begin : g_and
        assign out_and[j] = &vec[j+1:0];
    end

    // sample is registered and is high exactly on the last hold cycle of
    // each vector in RUN, so it doubles as the "commit this vector" strobe.
    // abort overrides both start and sample commits.
    assign start_go  = start && !abort && (state != RUN);
    assign sample_go = sample && !abort;

    // Sweep controller: state, vector, hold counter and all status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            vec      <= '0;
            hold_cnt <= '0;
            sample   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ones_cnt <= '0;
        end else if (abort) begin
            // Results of the interrupted sweep stay visible on ones_cnt.
            state    <= IDLE;
            vec      <= '0;
            hold_cnt <= '0;
            sample   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        vec      <= '0;
                        hold_cnt <= '0;
                        ones_cnt <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        sample   <= HOLD_ONE;
                    end
                end
                RUN: begin
                    if (sample) begin
                        hold_cnt <= '0;
                        if (out_and[N-2] && (ones_cnt != ONES_MAX)) begin
                            ones_cnt <= ones_cnt + (N+1)'(1);
                        end
                        if (vec == VEC_LAST) begin
                            state  <= DONE;
                            vec    <= '0;
                            sample <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            vec    <= vec + N'(1);
                            sample <= HOLD_ONE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HCW'(1);
                        sample   <= ((hold_cnt + HCW'(1)) == HOLD_LAST);
                    end
                end
                default: begin
                    state    <= IDLE;
                    vec      <= '0;
                    hold_cnt <= '0;
                    sample   <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef GATE_SWEEP_MISR_EN
    // One MISR step: shift left, feed back taps 7,5,4,3, then fold in the data.
    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ d;
    endfunction

    logic [7:0] misr_d;

    // {out_and, out_not} is at most 8 bits wide, so the cast only zero-extends.
    assign misr_d = 8'({out_and, out_not});

    // Signature register: cleared on reset and sweep start, advanced per sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (start_go) begin
            sig <= '0;
        end else if (sample_go) begin
            sig <= misr_step(sig, misr_d);
        end
    end
`else
    assign sig = 8'h00;
`endif

endmodule

// File: tb/tb_gate_sweep.sv
// Testbench for gate_sweep. It uses a default instance (N=3, HOLD=4) and a
// minimum instance (N=2, HOLD=1). Expected sample and done events are queued
// when a sweep starts. Per-instance monitors pop and compare them whenever
// the DUT pulses sample or raises done.
module tb_gate_sweep;

    localparam int N0 = 3;
    localparam int H0 = 4;
    localparam int N1 = 2;
    localparam int H1 = 1;
`ifdef GATE_SWEEP_MISR_EN
    localparam bit MISR_ON = 1'b1;
`else
    localparam bit MISR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, start0, abort0, start1, abort1;

    logic [N0-1:0] a_vec;
    logic          a_not;
    logic [N0-2:0] a_and;
    logic          a_sample, a_busy, a_done;
    logic [N0:0]   a_ones;
    logic [7:0]    a_sig;

    logic [N1-1:0] b_vec;
    logic          b_not;
    logic [N1-2:0] b_and;
    logic          b_sample, b_busy, b_done;
    logic [N1:0]   b_ones;
    logic [7:0]    b_sig;

    gate_sweep #(.N(N0), .HOLD(H0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .vec(a_vec), .out_not(a_not), .out_and(a_and), .sample(a_sample),
        .busy(a_busy), .done(a_done), .ones_cnt(a_ones), .sig(a_sig)
    );

    gate_sweep #(.N(N1), .HOLD(H1)) u_min (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .vec(b_vec), .out_not(b_not), .out_and(b_and), .sample(b_sample),
        .busy(b_busy), .done(b_done), .ones_cnt(b_ones), .sig(b_sig)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int is_done;
        int vec;
        int onot;
        int oand;
        int ones;
        int sig;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: AND-k is 1 when the low k bits of v are all ones.
    function automatic int and_vec(input int n, input int v);
        int r = 0;
        for (int j = 0; j < n - 1; j++)
            if ((v % (1 << (j + 2))) == (1 << (j + 2)) - 1) r += (1 << j);
        return r;
    endfunction

    function automatic int not_vec(input int v);
        return ((v % 2) == 0) ? 1 : 0;
    endfunction

    function automatic int misr(input int s, input int d);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((((s << 1) & 'hFE) | fb) ^ d) & 'hFF;
    endfunction

    // Signature after all samples whose RUN-cycle offset is below ncyc.
    function automatic int sig_upto(input int n, input int h, input int ncyc);
        int s = 0;
        if (!MISR_ON) return 0;
        for (int v = 0; v < (1 << n); v++)
            if (v * h + h - 1 < ncyc) s = misr(s, (and_vec(n, v) << 1) | not_vec(v));
        return s;
    endfunction

    task automatic push_sweep(input int inst, input int c0);
        int n = (inst == 0) ? N0 : N1;
        int h = (inst == 0) ? H0 : H1;
        ev_t e;
        for (int v = 0; v < (1 << n); v++) begin
            e.cyc = c0 + v * h + h - 1;
            e.is_done = 0;
            e.vec = v;
            e.onot = not_vec(v);
            e.oand = and_vec(n, v);
            e.ones = 0;
            e.sig = sig_upto(n, h, v * h + h - 1);
            if (inst == 0) q0.push_back(e); else q1.push_back(e);
        end
        e.cyc = c0 + (1 << n) * h;
        e.is_done = 1;
        e.vec = 0;
        e.onot = 1;
        e.oand = 0;
        e.ones = 1;
        e.sig = sig_upto(n, h, (1 << n) * h);
        if (inst == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic flush_from(input int inst, input int from_cyc);
        if (inst == 0) begin
            while (q0.size() > 0 && q0[q0.size() - 1].cyc >= from_cyc) void'(q0.pop_back());
        end else begin
            while (q1.size() > 0 && q1[q1.size() - 1].cyc >= from_cyc) void'(q1.pop_back());
        end
    endtask

    task automatic wait_until(input int target, input string name);
        int guard = 0;
        while (cyc < target && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        chk(name, cyc, target);
    endtask

    task automatic do_start(input int inst, output int c0);
        @(negedge clk);
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        c0 = cyc;
        push_sweep(inst, c0);
        if (inst == 0) begin
            chk("a_busy_first_run", a_busy, 1);
            chk("a_vec_first_run", a_vec, 0);
        end else begin
            chk("b_busy_first_run", b_busy, 1);
            chk("b_vec_first_run", b_vec, 0);
        end
    endtask

    task automatic finish_sweep(input int inst, input int c0);
        if (inst == 0) begin
            wait_until(c0 + (1 << N0) * H0 + 1, "a_reach_done");
            chk("a_queue_drained", q0.size(), 0);
            chk("a_done_held", a_done, 1);
            chk("a_busy_in_done", a_busy, 0);
        end else begin
            wait_until(c0 + (1 << N1) * H1 + 1, "b_reach_done");
            chk("b_queue_drained", q1.size(), 0);
            chk("b_done_held", b_done, 1);
            chk("b_busy_in_done", b_busy, 0);
        end
    endtask

    task automatic chk_reset_a();
        chk("rst_a_vec", a_vec, 0);
        chk("rst_a_not", a_not, 1);
        chk("rst_a_and", a_and, 0);
        chk("rst_a_sample", a_sample, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_ones", a_ones, 0);
        chk("rst_a_sig", a_sig, 0);
    endtask

    // Monitor for the default instance.
    initial begin : mon0
        logic done_q;
        ev_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && (a_sample === 1'b1 || (a_done === 1'b1 && done_q !== 1'b1))) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_event: sample=%b done=%b at cycle %0d, expected none",
                             a_sample, a_done, cyc);
                end else begin
                    e = q0.pop_front();
                    chk("a_ev_cycle", cyc, e.cyc);
                    chk("a_ev_kind", a_done, e.is_done);
                    chk("a_ev_vec", a_vec, e.vec);
                    chk("a_ev_not", a_not, e.onot);
                    chk("a_ev_and", a_and, e.oand);
                    chk("a_ev_ones", a_ones, e.ones);
                    chk("a_ev_sig", a_sig, e.sig);
                    if (e.is_done != 0) chk("a_ev_busy_at_done", a_busy, 0);
                end
            end
            done_q = a_done;
        end
    end

    // Monitor for the minimum instance.
    initial begin : mon1
        logic done_q;
        ev_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && (b_sample === 1'b1 || (b_done === 1'b1 && done_q !== 1'b1))) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_event: sample=%b done=%b at cycle %0d, expected none",
                             b_sample, b_done, cyc);
                end else begin
                    e = q1.pop_front();
                    chk("b_ev_cycle", cyc, e.cyc);
                    chk("b_ev_kind", b_done, e.is_done);
                    chk("b_ev_vec", b_vec, e.vec);
                    chk("b_ev_not", b_not, e.onot);
                    chk("b_ev_and", b_and, e.oand);
                    chk("b_ev_ones", b_ones, e.ones);
                    chk("b_ev_sig", b_sig, e.sig);
                    if (e.is_done != 0) chk("b_ev_busy_at_done", b_busy, 0);
                end
            end
            done_q = b_done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int c0;
        int r;
        int sig_keep;
        rst_n = 1'b0;
        start0 = 1'b0;
        abort0 = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_a();
        chk("rst_b_vec", b_vec, 0);
        chk("rst_b_not", b_not, 1);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_ones", b_ones, 0);
        rst_n = 1'b1;

        // Full sweep, then a back-to-back restart from DONE
        do_start(0, c0);
        wait_until(c0 + (1 << N0) * H0 - 1, "a_last_run_cycle");
        do_start(0, c0);
        finish_sweep(0, c0);

        // start during RUN must not change the sweep length
        do_start(0, c0);
        wait_until(c0 + 10, "a_mid_sweep");
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        finish_sweep(0, c0);

        // abort at vec=5
        do_start(0, c0);
        wait_until(c0 + 5 * H0, "a_at_vec5");
        chk("a_vec_before_abort", a_vec, 5);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        flush_from(0, cyc);
        sig_keep = sig_upto(N0, H0, 5 * H0);
        chk("abort_vec", a_vec, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        chk("abort_ones", a_ones, 0);
        chk("abort_sig_kept", a_sig, sig_keep);

        // start and abort together in IDLE: abort wins, results untouched
        @(negedge clk);
        start0 = 1'b1;
        abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort0 = 1'b0;
        chk("both_busy", a_busy, 0);
        repeat (4) @(negedge clk);
        chk("both_busy_later", a_busy, 0);
        chk("both_vec", a_vec, 0);
        chk("both_sig_kept", a_sig, sig_keep);

        // Randomized sweeps: random gaps, then either a random abort or a spurious start
        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_start(0, c0);
            r = $urandom_range(1, (1 << N0) * H0 - 1);
            wait_until(c0 + r, "rnd_point");
            if ($urandom_range(0, 1) == 1) begin
                abort0 = 1'b1;
                @(negedge clk);
                abort0 = 1'b0;
                flush_from(0, cyc);
                chk("rnd_abort_vec", a_vec, 0);
                chk("rnd_abort_busy", a_busy, 0);
                chk("rnd_abort_sig", a_sig, sig_upto(N0, H0, r));
            end else begin
                start0 = 1'b1;
                @(negedge clk);
                start0 = 1'b0;
                finish_sweep(0, c0);
            end
        end

        // Reset mid-sweep drops everything
        do_start(0, c0);
        wait_until(c0 + 14, "a_before_reset");
        rst_n = 1'b0;
        @(negedge clk);
        flush_from(0, 0);
        chk_reset_a();
        rst_n = 1'b1;
        @(negedge clk);

        // Minimum configuration N=2, HOLD=1
        do_start(1, c0);
        finish_sweep(1, c0);
        chk("b_sig_const", b_sig, sig_upto(N1, H1, (1 << N1) * H1));

        repeat (3) @(negedge clk);
        chk("final_a_queue", q0.size(), 0);
        chk("final_b_queue", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
